// File: rtl/fc8_joypad_ctrl.sv
// Joypad front end: per-input synchronizer and debouncer, a held-state register
// and a clear-on-read pressed-event register. Define FC8_JOYPAD_SOCD_EN for opposite-direction cleaning.
module fc8_joypad_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk_20mhz,
  input  logic       rst,
  input  logic       raw_joy_up,
  input  logic       raw_joy_down,
  input  logic       raw_joy_left,
  input  logic       raw_joy_right,
  input  logic       raw_button_a,
  input  logic       raw_button_b,
  input  logic       rd_strobe,
  input  logic       rd_sel,
  output logic [7:0] rd_data,
  output logic       irq
);

  localparam int unsigned NUM_IN = 6;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] r_sync1;
  logic [NUM_IN-1:0] r_sync2;
  logic [NUM_IN-1:0] r_stable;
  logic [CW-1:0]     r_cnt [NUM_IN];
  logic [NUM_IN-1:0] r_flags;
  logic [7:0]        r_rd_data;
  logic              r_irq;

  logic [NUM_IN-1:0] w_diff;
  logic [NUM_IN-1:0] w_load;
  logic [NUM_IN-1:0] w_rise;
  logic [NUM_IN-1:0] w_stable_next;
  logic [CW-1:0]     w_cnt_next [NUM_IN];
  logic [NUM_IN-1:0] w_flags_next;
  logic [NUM_IN-1:0] w_held;
  logic              w_clr;

  assign w_raw = {raw_button_b, raw_button_a, raw_joy_right,
                  raw_joy_left, raw_joy_down, raw_joy_up};

  // A changed level must persist DEBOUNCE_CYCLES synchronized cycles before it is accepted.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
    assign w_diff[gi]        = r_sync2[gi] ^ r_stable[gi];
    assign w_load[gi]        = w_diff[gi] && (r_cnt[gi] == CNT_LAST);
    assign w_cnt_next[gi]    = (!w_diff[gi] || w_load[gi]) ? '0 : r_cnt[gi] + 1'b1;
    assign w_stable_next[gi] = w_load[gi] ? r_sync2[gi] : r_stable[gi];
    assign w_rise[gi]        = w_load[gi] & r_sync2[gi];
  end

  // A rise coinciding with a clearing read survives the clear but is not returned.
  assign w_clr        = rd_strobe & rd_sel;
  assign w_flags_next = (r_flags & ~{NUM_IN{w_clr}}) | w_rise;

`ifdef FC8_JOYPAD_SOCD_EN
  always_comb begin
    w_held = r_stable;
    if (r_stable[0] && r_stable[1]) w_held[1:0] = 2'b00;
    if (r_stable[2] && r_stable[3]) w_held[3:2] = 2'b00;
  end
`else
  assign w_held = r_stable;
`endif

  always_ff @(posedge clk_20mhz) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_cnt     <= '{default: '0};
      r_flags   <= '0;
      r_rd_data <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_next;
      for (int i = 0; i < NUM_IN; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_flags <= w_flags_next;
      if (rd_strobe) begin
        r_rd_data <= rd_sel ? {2'b00, r_flags} : {2'b00, w_held};
      end
      r_irq <= |r_flags;
    end
  end

  assign rd_data = r_rd_data;
  assign irq     = r_irq;

endmodule
